// File: rtl/common_sync_pkg.sv
// Shared types and helpers for the destination-domain synchronizer/filter slice.
// Holds the edge-filter state encoding, the glitch counter width and the run-counter width helper.
package common_sync_pkg;

    typedef enum logic {
        STABLE    = 1'b0,
        CANDIDATE = 1'b1
    } filt_state_e;

    localparam int GLITCH_CNT_W = 8;

    // Run counter only needs to reach FILT_CNT-1, but never shrink below one bit.
    function automatic int filt_cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_filter.sv
// Glitch filter for a synchronized level: emits a clean level plus rise/fall strobes; optional glitch count under SYNC_EDGE_FILTER_GLITCH_CNT_EN.
// Latency: FILT_CNT dest_clk cycles from a D_in change to D_filt; no backpressure, en=0 freezes the output and drops any candidate.
module sync_edge_filter
    import common_sync_pkg::*;
#(
    parameter int   FILT_CNT  = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic                    dest_clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    D_in,
    output logic                    D_filt,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int               RUN_W    = filt_cnt_w(FILT_CNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_CNT - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_filt_cnt
        $error("sync_edge_filter: FILT_CNT must lie in 1..255");
    end

    filt_state_e      state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic             accept;

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        accept    = 1'b0;
        case (state)
            STABLE: begin
                if (en && (D_in != D_filt)) begin
                    if (FILT_CNT == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = CANDIDATE;
                        run_nxt   = RUN_ONE;
                    end
                end
            end
            CANDIDATE: begin
                // Disable and glitch both abandon the candidate; only the glitch is counted.
                if (!en || (D_in == D_filt)) begin
                    state_nxt = STABLE;
                    run_nxt   = '0;
                end else if (run == RUN_LAST) begin
                    accept    = 1'b1;
                    state_nxt = STABLE;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run + RUN_ONE;
                end
            end
            default: begin
                state_nxt = STABLE;
                run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge dest_clk) begin
        if (!rstn) begin
            state      <= STABLE;
            run        <= '0;
            D_filt     <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            run        <= run_nxt;
            D_filt     <= accept ? ~D_filt : D_filt;
            rise_pulse <= accept & ~D_filt;
            fall_pulse <= accept & D_filt;
        end
    end

`ifdef SYNC_EDGE_FILTER_GLITCH_CNT_EN
    logic                    glitch_evt;
    logic [GLITCH_CNT_W-1:0] glitch_q;

    assign glitch_evt = (state == CANDIDATE) && en && (D_in == D_filt);

    always_ff @(posedge dest_clk) begin
        if (!rstn) begin
            glitch_q <= '0;
        end else if (glitch_evt && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_CNT_W'(1);
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter: three instances (FILT_CNT=4/RESET_VAL=0, FILT_CNT=4/RESET_VAL=1, FILT_CNT=1).
// Glitch-count expectations follow SYNC_EDGE_FILTER_GLITCH_CNT_EN.
module tb_sync_edge_filter;

`ifdef SYNC_EDGE_FILTER_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       en;
    logic       d0, d1, d2;
    logic       f0, r0, fa0;
    logic       f1, r1, fa1;
    logic       f2, r2, fa2;
    logic [7:0] g0, g1, g2;

    int checks = 0;
    int errors = 0;

    sync_edge_filter #(.FILT_CNT(4), .RESET_VAL(1'b0)) u0 (
        .dest_clk(clk), .rstn(rstn), .en(en), .D_in(d0),
        .D_filt(f0), .rise_pulse(r0), .fall_pulse(fa0), .glitch_cnt(g0)
    );

    sync_edge_filter #(.FILT_CNT(4), .RESET_VAL(1'b1)) u1 (
        .dest_clk(clk), .rstn(rstn), .en(en), .D_in(d1),
        .D_filt(f1), .rise_pulse(r1), .fall_pulse(fa1), .glitch_cnt(g1)
    );

    sync_edge_filter #(.FILT_CNT(1), .RESET_VAL(1'b0)) u2 (
        .dest_clk(clk), .rstn(rstn), .en(en), .D_in(d2),
        .D_filt(f2), .rise_pulse(r2), .fall_pulse(fa2), .glitch_cnt(g2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic       seen;
        logic       prev;
        logic [5:0] pat;

        rstn = 1'b0;
        en   = 1'b1;
        d0   = 1'b0;
        d1   = 1'b0;
        d2   = 1'b0;
        step();
        step();

        chk("rst_f0",  f0,  8'd0);
        chk("rst_r0",  r0,  8'd0);
        chk("rst_fa0", fa0, 8'd0);
        chk("rst_g0",  g0,  8'd0);
        chk("rst_f1",  f1,  8'd1);
        chk("rst_fa1", fa1, 8'd0);
        chk("rst_f2",  f2,  8'd0);

        // Reset exit with D_in differing from RESET_VAL: no pulse, then a normal fall after 4 cycles.
        rstn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("rexit_f1",  f1,  8'(i < 4));
            chk("rexit_fa1", fa1, 8'(i == 4));
            chk("rexit_r1",  r1,  8'd0);
        end

        // Clean rise then clean fall on u0.
        d0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("rise_f0",  f0,  8'(i >= 4));
            chk("rise_r0",  r0,  8'(i == 4));
            chk("rise_fa0", fa0, 8'd0);
        end
        d0 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("fall_f0",  f0,  8'(i < 4));
            chk("fall_fa0", fa0, 8'(i == 4));
            chk("fall_r0",  r0,  8'd0);
        end

        // Three-cycle pulse is one short of acceptance.
        d0 = 1'b1;
        step();
        step();
        step();
        d0 = 1'b0;
        step();
        chk("glitch_f0", f0, 8'd0);
        chk("glitch_r0", r0, 8'd0);
        chk("glitch_g0", g0, GC_EN ? 8'd1 : 8'd0);
        step();
        chk("glitch_f0_hold", f0, 8'd0);

        // 300 two-cycle glitches drive the counter into saturation.
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            d0 = 1'b1;
            step();
            seen |= r0 | fa0 | f0;
            step();
            seen |= r0 | fa0 | f0;
            d0 = 1'b0;
            step();
            seen |= r0 | fa0 | f0;
        end
        chk("sat_no_edge", 8'(seen), 8'd0);
        chk("sat_g0",      g0,       GC_EN ? 8'd255 : 8'd0);
        d0 = 1'b1;
        step();
        step();
        d0 = 1'b0;
        step();
        chk("sat_hold_g0", g0, GC_EN ? 8'd255 : 8'd0);

        // en dropped on the second candidate cycle; filtering restarts from scratch on re-enable.
        d0 = 1'b1;
        step();
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("en_off_f0", f0, 8'd0);
            chk("en_off_r0", r0, 8'd0);
        end
        chk("en_off_g0", g0, GC_EN ? 8'd255 : 8'd0);
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("en_on_f0", f0, 8'(i >= 4));
            chk("en_on_r0", r0, 8'(i == 4));
        end
        chk("en_on_g0", g0, GC_EN ? 8'd255 : 8'd0);

        // Return u0 low, then reset during candidate cycle 3 of a rise.
        d0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("pre_f0",  f0,  8'(i < 4));
            chk("pre_fa0", fa0, 8'(i == 4));
        end
        d0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("cand_f0", f0, 8'd0);
        end
        rstn = 1'b0;
        step();
        chk("mid_rst_f0",  f0,  8'd0);
        chk("mid_rst_r0",  r0,  8'd0);
        chk("mid_rst_g0",  g0,  8'd0);
        chk("mid_rst_f1",  f1,  8'd1);
        chk("mid_rst_r1",  r1,  8'd0);
        chk("mid_rst_fa1", fa1, 8'd0);
        rstn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("post_rst_f0",  f0,  8'(i >= 4));
            chk("post_rst_r0",  r0,  8'(i == 4));
            chk("post_rst_f1",  f1,  8'(i < 4));
            chk("post_rst_fa1", fa1, 8'(i == 4));
        end

        // FILT_CNT=1: output tracks the input with one cycle of latency, single-cycle pulses included.
        pat  = 6'b001011;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d2 = pat[i];
            step();
            chk("f1x_f2",  f2,  8'(pat[i]));
            chk("f1x_r2",  r2,  8'(pat[i] & ~prev));
            chk("f1x_fa2", fa2, 8'(~pat[i] & prev));
            prev = pat[i];
        end
        chk("f1x_g2", g2, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
